// File: rtl/timer_sequencer_pkg.sv
// rtl/timer_sequencer_pkg.sv - shared state encoding and reset defaults for the timer sequencer
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } tstate_e;

   // Wide enough for any supported WIDTH/PRESC_W; users slice the low bits.
   localparam logic [31:0] LIMIT_RST = 32'hFFFF_FFFF;
   localparam logic [31:0] PRESC_RST = 32'h0000_0000;

endpackage

// File: rtl/timer_sequencer_if.sv
// rtl/timer_sequencer_if.sv - control/config/status bundle between CPU-side registers and the timer
interface timer_sequencer_if #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
);
   import timer_pkg::*;

   logic               cfg_we;
   logic [WIDTH-1:0]   cfg_limit;
   logic [PRESC_W-1:0] cfg_presc;
   logic               cfg_periodic;
   logic               start;
   logic               pause;
   logic               stop;
   logic [WIDTH-1:0]   count;
   logic               expire;
   logic               busy;
   tstate_e            state;

   modport master (
      output cfg_we, cfg_limit, cfg_presc, cfg_periodic, start, pause, stop,
      input  count, expire, busy, state
   );

   modport slave (
      input  cfg_we, cfg_limit, cfg_presc, cfg_periodic, start, pause, stop,
      output count, expire, busy, state
   );

endinterface

// File: rtl/timer_sequencer_tick_counter.sv
// rtl/timer_sequencer_tick_counter.sv - count register with clear, enable, terminal compare and wrap
module tick_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             at_limit
);

   // Plain unsigned increment: rolls over at 2^WIDTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

   assign at_limit = (count == limit);

endmodule

// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - programmable timer: prescaler, run/hold/done FSM and expiry pulse
module timer_sequencer
   import timer_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input logic               clk,
   input logic               reset,
   timer_sequencer_if.slave  bus
);

   tstate_e            state_r;
   logic [PRESC_W-1:0] pcnt;
   logic [PRESC_W-1:0] presc_r;
   logic [WIDTH-1:0]   limit_r;
   logic               periodic_r;
   logic               expire_r;
   logic               busy_r;

   logic [WIDTH-1:0]   count_w;
   logic               at_limit;
   logic               cfg_ok;
   logic               launch;
   logic               tick;
   logic               terminal;
   logic               cnt_clear;
   logic               cnt_en;

   // stop > pause > start; a tick only exists in an uninterrupted RUN cycle,
   // so a coinciding stop or pause drops the tick (and any expiry) entirely.
   always_comb begin
      cfg_ok    = (state_r == IDLE) || (state_r == DONE);
      launch    = cfg_ok && bus.start && !bus.stop && !bus.pause;
      tick      = (state_r == RUN) && !bus.stop && !bus.pause && (pcnt == presc_r);
      terminal  = tick && at_limit;
      cnt_clear = bus.stop || launch || (terminal && periodic_r);
      cnt_en    = tick && !at_limit;
   end

   tick_counter #(
      .WIDTH (WIDTH)
   ) u_tick_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .enable   (cnt_en),
      .limit    (limit_r),
      .count    (count_w),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         pcnt       <= '0;
         expire_r   <= 1'b0;
         busy_r     <= 1'b0;
         limit_r    <= LIMIT_RST[WIDTH-1:0];
         presc_r    <= PRESC_RST[PRESC_W-1:0];
         periodic_r <= 1'b0;
      end else begin
         expire_r <= 1'b0;

         // Config latched alongside a launch is what the new run sees.
         if (cfg_ok && bus.cfg_we) begin
            limit_r    <= bus.cfg_limit;
            presc_r    <= bus.cfg_presc;
            periodic_r <= bus.cfg_periodic;
         end

         case (state_r)
            IDLE, DONE: begin
               if (bus.stop) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else if (launch) begin
                  state_r <= RUN;
                  pcnt    <= '0;
                  busy_r  <= 1'b1;
               end
            end
            RUN: begin
               if (bus.stop) begin
                  state_r <= IDLE;
                  pcnt    <= '0;
                  busy_r  <= 1'b0;
               end else if (bus.pause) begin
                  state_r <= HOLD;
               end else begin
                  pcnt <= tick ? '0 : pcnt + 1'b1;
                  if (terminal) begin
                     expire_r <= 1'b1;
                     if (!periodic_r) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                     end
                  end
               end
            end
            HOLD: begin
               if (bus.stop) begin
                  state_r <= IDLE;
                  pcnt    <= '0;
                  busy_r  <= 1'b0;
               end else if (!bus.pause && bus.start) begin
                  state_r <= RUN;
               end
            end
         endcase
      end
   end

   assign bus.count  = count_w;
   assign bus.expire = expire_r;
   assign bus.busy   = busy_r;
   assign bus.state  = state_r;

endmodule

// File: tb/tb_timer_sequencer.sv
// tb/tb_timer_sequencer.sv - directed self-checking bench for timer_sequencer
module tb_timer_sequencer;
   import timer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   timer_sequencer_if #(.WIDTH(8), .PRESC_W(4)) bus ();

   timer_sequencer #(
      .WIDTH   (8),
      .PRESC_W (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic config_timer(input logic [7:0] lim, input logic [3:0] pr, input logic per);
      bus.cfg_we       = 1'b1;
      bus.cfg_limit    = lim;
      bus.cfg_presc    = pr;
      bus.cfg_periodic = per;
      step();
      bus.cfg_we       = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
   endtask

   int per_cnt [0:6] = '{0, 0, 1, 1, 2, 2, 0};

   initial begin
      reset            = 1'b1;
      bus.cfg_we       = 1'b0;
      bus.cfg_limit    = 8'd0;
      bus.cfg_presc    = 4'd0;
      bus.cfg_periodic = 1'b0;
      bus.start        = 1'b0;
      bus.pause        = 1'b0;
      bus.stop         = 1'b0;
      #12;
      reset = 1'b0;
      check("rst_state",  bus.state,  0);
      check("rst_count",  bus.count,  0);
      check("rst_expire", bus.expire, 0);
      check("rst_busy",   bus.busy,   0);

      // One-shot, limit 3, no prescale
      config_timer(8'd3, 4'd0, 1'b0);
      pulse_start();
      check("os_state_run", bus.state, 1);
      check("os_count_e0",  bus.count, 0);
      check("os_busy",      bus.busy,  1);
      for (int k = 1; k <= 3; k++) begin
         step();
         check("os_count",  bus.count,  k);
         check("os_noexp",  bus.expire, 0);
      end
      step();
      check("os_expire",     bus.expire, 1);
      check("os_state_done", bus.state,  3);
      check("os_count_hold", bus.count,  3);
      check("os_busy_done",  bus.busy,   0);
      step();
      check("os_expire_once", bus.expire, 0);
      check("os_count_held",  bus.count,  3);

      // Periodic, limit 2, presc 1
      config_timer(8'd2, 4'd1, 1'b1);
      pulse_start();
      check("per_count_e0", bus.count, per_cnt[0]);
      for (int k = 1; k <= 18; k++) begin
         step();
         if (k <= 6) check("per_count", bus.count, per_cnt[k]);
         check("per_expire", bus.expire, (k % 6 == 0) ? 1 : 0);
      end
      check("per_state_run", bus.state, 1);
      pulse_stop();
      check("per_stop_state", bus.state, 0);
      check("per_stop_count", bus.count, 0);
      check("per_stop_busy",  bus.busy,  0);

      // Pause at count 5; ten non-counting edges shift expiry from E+10 to E+20
      config_timer(8'd9, 4'd0, 1'b0);
      pulse_start();
      repeat (5) step();
      check("pr_count5", bus.count, 5);
      bus.pause = 1'b1;
      repeat (9) step();
      bus.pause = 1'b0;
      check("pr_hold_state", bus.state, 2);
      check("pr_hold_count", bus.count, 5);
      check("pr_hold_busy",  bus.busy,  1);
      pulse_start();
      check("pr_resume_state", bus.state, 1);
      check("pr_resume_count", bus.count, 5);
      repeat (4) step();
      check("pr_count9",  bus.count,  9);
      check("pr_noexp19", bus.expire, 0);
      step();
      check("pr_expire20", bus.expire, 1);
      check("pr_done",     bus.state,  3);

      // Stop on the terminal tick
      config_timer(8'd3, 4'd0, 1'b0);
      pulse_start();
      repeat (3) step();
      check("st_count3", bus.count, 3);
      pulse_stop();
      check("st_noexp", bus.expire, 0);
      check("st_state", bus.state,  0);
      check("st_count", bus.count,  0);
      pulse_start();
      step();
      check("st_restart_count", bus.count, 1);
      repeat (3) step();
      check("st_restart_expire", bus.expire, 1);

      // cfg_we during RUN is ignored
      config_timer(8'd4, 4'd0, 1'b1);
      pulse_start();
      bus.cfg_we       = 1'b1;
      bus.cfg_limit    = 8'd9;
      bus.cfg_periodic = 1'b0;
      step();
      bus.cfg_we       = 1'b0;
      check("cfgrun_count1", bus.count, 1);
      repeat (3) step();
      check("cfgrun_count4", bus.count,  4);
      check("cfgrun_noexp",  bus.expire, 0);
      step();
      check("cfgrun_expire",  bus.expire, 1);
      check("cfgrun_still_periodic", bus.state, 1);
      check("cfgrun_wrap0",   bus.count,  0);
      pulse_stop();
      // cfg_we together with start in IDLE takes effect for this run
      bus.cfg_we       = 1'b1;
      bus.cfg_limit    = 8'd9;
      bus.cfg_presc    = 4'd0;
      bus.cfg_periodic = 1'b0;
      bus.start        = 1'b1;
      step();
      bus.cfg_we       = 1'b0;
      bus.start        = 1'b0;
      repeat (9) step();
      check("cfgidle_count9", bus.count,  9);
      check("cfgidle_noexp",  bus.expire, 0);
      step();
      check("cfgidle_expire", bus.expire, 1);
      check("cfgidle_done",   bus.state,  3);

      // limit 0, periodic: expire on every tick, count stays 0
      config_timer(8'd0, 4'd0, 1'b1);
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         step();
         check("lim0_expire", bus.expire, 1);
         check("lim0_count",  bus.count,  0);
      end
      pulse_stop();

      // Async reset between edges while running
      config_timer(8'd9, 4'd0, 1'b0);
      pulse_start();
      repeat (7) step();
      check("ar_count7", bus.count, 7);
      #2;
      reset = 1'b1;
      #1;
      check("ar_count", bus.count,  0);
      check("ar_state", bus.state,  0);
      check("ar_busy",  bus.busy,   0);
      check("ar_exp",   bus.expire, 0);
      step();
      check("ar_exp_held", bus.expire, 0);
      reset = 1'b0;

      // Reset default limit is all-ones
      pulse_start();
      repeat (255) step();
      check("dflt_count255", bus.count,  255);
      check("dflt_noexp",    bus.expire, 0);
      step();
      check("dflt_expire",   bus.expire, 1);
      check("dflt_done",     bus.state,  3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
